// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants.
// Holds the data width, register address width, the architectural register
// indices with special meaning (x0, sp) and the stack pointer reset value.
// Used by the register file, the decoder and the ALU path.
package riscv_pkg;

  localparam int XLEN         = 32'sd32;
  localparam int REG_ADDR_W   = 32'sd5;
  localparam int NREG_DEFAULT = 32'sd32;

  localparam int REG_ZERO = 32'sd0;
  localparam int REG_SP   = 32'sd2;

  localparam logic [XLEN-1:0] SP_INIT_DEFAULT = 32'h0000_0FFC;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the integer register file.
// Selects one register out of the flattened array, forces x0 and
// out-of-range addresses to zero, and optionally forwards the write data
// when the port reads the register being written in the same cycle.
// Ports:
//   regs_flat  in  NREG*XLEN  flattened register array (entry i at [i*XLEN +: XLEN])
//   addr       in  AW         read address
//   wr_act     in  1          a write to an in-range, nonzero register happens this edge
//   wr_addr    in  AW         write address
//   wr_data    in  XLEN       write data
//   rd_data    out XLEN       read data (combinational)
module rf_read_port
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int NREG   = riscv_pkg::NREG_DEFAULT,
  parameter int AW     = riscv_pkg::REG_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic [NREG*XLEN-1:0] regs_flat,
  input  logic [AW-1:0]        addr,
  input  logic                 wr_act,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  output logic [XLEN-1:0]      rd_data
);

  logic [XLEN-1:0] arr_s;

  // Array mux; an address with no matching entry (out of range) yields zero.
  always_comb begin
    arr_s = '0;
    for (int i = 32'sd0; i < NREG; i++) begin
      arr_s = (addr == AW'(i)) ? regs_flat[i*XLEN +: XLEN] : arr_s;
    end
  end

  // x0 masking has priority over the bypass; wr_act already excludes x0,
  // reset and out-of-range writes, so a match here is always a real write.
  always_comb begin
    rd_data = '0;
    if (addr == AW'(REG_ZERO)) begin
      rd_data = '0;
    end else if (BYPASS && wr_act && (addr == wr_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = arr_s;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Integer register file of the single-cycle RISC-V core.
// NREG x XLEN registers, two combinational read ports (RD1 -> ALU Src_A,
// RD2 -> Src_B mux / store data), one synchronous write port fed by the
// write-back mux, x0 hardwired to zero, optional write-to-read bypass and
// an unbypassed debug read port.
// Ports:
//   clk       in  1     core clock, rising edge
//   rst_n     in  1     synchronous reset, active low
//   A1, A2    in  AW    read addresses (rs1, rs2)
//   A3        in  AW    write address (rd)
//   WE3       in  1     write enable (RegWrite)
//   WD3       in  XLEN  write data (Result)
//   RD1, RD2  out XLEN  read data
//   dbg_addr  in  AW    debug read address
//   dbg_data  out XLEN  debug read data, never bypassed
module reg_file
  import riscv_pkg::*;
#(
  parameter int               XLEN    = riscv_pkg::XLEN,
  parameter int               NREG    = riscv_pkg::NREG_DEFAULT,
  parameter int               AW      = riscv_pkg::REG_ADDR_W,
  parameter bit               BYPASS  = 1'b1,
  parameter logic [XLEN-1:0]  SP_INIT = riscv_pkg::SP_INIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic            WE3,
  input  logic [XLEN-1:0] WD3,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  logic [XLEN-1:0]      regs_r [NREG];
  logic [NREG*XLEN-1:0] regs_flat_s;
  logic                 wr_act_s;
  logic [XLEN-1:0]      dbg_arr_s;

  // A write only takes effect outside reset, to a nonzero in-range register.
  assign wr_act_s = rst_n && WE3 && (A3 != AW'(REG_ZERO)) && ({1'b0, A3} < NREG_W);

  for (genvar g = 32'sd0; g < NREG; g++) begin : g_flat
    assign regs_flat_s[g*XLEN +: XLEN] = regs_r[g];
  end

  // Register array: reset loads zeros except sp; x0 is never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 32'sd0; i < NREG; i++) begin
        regs_r[i] <= (i == REG_SP) ? SP_INIT : '0;
      end
    end else begin
      for (int i = 32'sd1; i < NREG; i++) begin
        if (wr_act_s && (A3 == AW'(i))) begin
          regs_r[i] <= WD3;
        end
      end
    end
  end

  rf_read_port #(
    .XLEN   (XLEN),
    .NREG   (NREG),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_rd1 (
    .regs_flat (regs_flat_s),
    .addr      (A1),
    .wr_act    (wr_act_s),
    .wr_addr   (A3),
    .wr_data   (WD3),
    .rd_data   (RD1)
  );

  rf_read_port #(
    .XLEN   (XLEN),
    .NREG   (NREG),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_rd2 (
    .regs_flat (regs_flat_s),
    .addr      (A2),
    .wr_act    (wr_act_s),
    .wr_addr   (A3),
    .wr_data   (WD3),
    .rd_data   (RD2)
  );

  // Debug array mux; out-of-range addresses find no entry and read zero.
  always_comb begin
    dbg_arr_s = '0;
    for (int i = 32'sd0; i < NREG; i++) begin
      dbg_arr_s = (dbg_addr == AW'(i)) ? regs_r[i] : dbg_arr_s;
    end
  end

  // Debug port: x0 masked, no bypass so it always shows the stored state.
  always_comb begin
    dbg_data = '0;
    if (dbg_addr == AW'(REG_ZERO)) begin
      dbg_data = '0;
    end else begin
      dbg_data = dbg_arr_s;
    end
  end

endmodule
